// File: rtl/golden_nonce_uart_tx.sv
// Queues golden nonces in a small FIFO and sends each one as four 8N1 UART
// bytes, most-significant byte first, with uart_tx driven from a register.
module golden_nonce_uart_tx #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                     hash_clk,
  input  logic                     reset,
  input  logic                     nonce_valid,
  input  logic [31:0]              nonce_in,
  output logic                     uart_tx,
  output logic                     busy,
  output logic                     overflow,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count,
  output logic [1:0]               dbg_state
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
  localparam int CW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]    LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                     r_state, w_state_nxt;
  logic [1:0]                 r_byte_idx, w_byte_nxt;
  logic [2:0]                 r_bit_idx, w_bit_nxt;
  logic [CW-1:0]              r_clk_cnt, w_cnt_nxt;
  logic [31:0]                r_shift, w_shift_nxt;
  logic                       r_tx, w_tx;
  logic                       r_overflow;
  logic [31:0]                r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]           r_count;
  logic                       w_pop, w_push, w_drop, w_bit_end;
  logic [7:0]                 w_cur_byte;

  // nonce_valid is a one-cycle strobe with no back-pressure: it is accepted
  // when there is room (or a pop frees a slot that cycle), otherwise dropped.
  assign w_push    = nonce_valid && ((r_count != DEPTH_C) || w_pop);
  assign w_drop    = nonce_valid && !w_push;
  assign w_bit_end = (r_clk_cnt == LAST_CLK);
  assign w_cur_byte = r_shift[31:24];

  always_comb begin
    w_state_nxt = r_state;
    w_byte_nxt  = r_byte_idx;
    w_bit_nxt   = r_bit_idx;
    w_cnt_nxt   = r_clk_cnt;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    w_tx        = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_byte_nxt  = 2'd0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx = 1'b0;
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = 3'd0;
          w_state_nxt = S_DATA;
        end else begin
          w_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        w_tx = w_cur_byte[r_bit_idx];
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
          else                   w_bit_nxt   = r_bit_idx + 1'b1;
        end else begin
          w_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_byte_idx == 2'd3) begin
            w_state_nxt = S_IDLE;
          end else begin
            // Next byte follows immediately; shifting keeps it in [31:24].
            w_byte_nxt  = r_byte_idx + 1'b1;
            w_shift_nxt = r_shift << 8;
            w_state_nxt = S_START;
          end
        end else begin
          w_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_byte_idx <= '0;
      r_bit_idx  <= '0;
      r_clk_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_overflow <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_idx <= w_byte_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_clk_cnt  <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx;
      if (w_drop) r_overflow <= 1'b1;
      if (w_push) begin
        r_mem[r_wr_ptr] <= nonce_in;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  assign uart_tx    = r_tx;
  assign busy       = (r_state != S_IDLE) || (r_count != '0);
  assign overflow   = r_overflow;
  assign fifo_count = r_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Bench for golden_nonce_uart_tx: UART receiver model plus nonce scoreboard,
// with one task per scenario.
module tb_golden_nonce_uart_tx;

  localparam int CPB = 4;
  localparam int L2  = 2;

  logic        hash_clk = 1'b0;
  logic        reset = 1'b1;
  logic        nonce_valid = 1'b0;
  logic [31:0] nonce_in = '0;
  logic        uart_tx, busy, overflow;
  logic [L2:0] fifo_count;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  rx_byte_q[$];
  int          rx_start_q[$];
  int          rx_err = 0;
  bit          sb_en = 1'b1;

  golden_nonce_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(L2)) dut (
    .hash_clk(hash_clk), .reset(reset), .nonce_valid(nonce_valid),
    .nonce_in(nonce_in), .uart_tx(uart_tx), .busy(busy),
    .overflow(overflow), .fifo_count(fifo_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 hash_clk = ~hash_clk;
  always @(posedge hash_clk) cyc <= cyc + 1;

  // Reference receiver: detects a falling edge and samples mid-bit.
  initial begin : rx_model
    logic       prev;
    logic [7:0] b;
    bit         ok;
    prev = 1'b1;
    forever begin
      @(negedge hash_clk);
      if (prev === 1'b1 && uart_tx === 1'b0) begin
        rx_start_q.push_back(cyc);
        repeat (CPB / 2) @(negedge hash_clk);
        ok = (uart_tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge hash_clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge hash_clk);
        if (uart_tx !== 1'b1) ok = 1'b0;
        rx_byte_q.push_back(b);
        if (!ok) rx_err++;
      end
      prev = uart_tx;
    end
  end

  // Scoreboard: every four received bytes form one nonce, MSB first.
  initial begin : scoreboard
    logic [31:0] got, exp;
    forever begin
      @(negedge hash_clk);
      if (rx_byte_q.size() >= 4) begin
        got = {rx_byte_q[0], rx_byte_q[1], rx_byte_q[2], rx_byte_q[3]};
        repeat (4) void'(rx_byte_q.pop_front());
        if (sb_en) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_frame got=%h exp=none", got);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              errors++;
              $display("FAIL sb_frame got=%h exp=%h", got, exp);
            end
          end
        end
      end
    end
  end

  // driver tasks (called at a negedge, return at a negedge)
  task automatic push(input logic [31:0] v);
    nonce_valid = 1'b1;
    nonce_in    = v;
    @(negedge hash_clk);
    nonce_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int t = 0; t < budget && exp_q.size() != 0; t++) @(negedge hash_clk);
    repeat (4) @(negedge hash_clk);
  endtask

  task automatic clear_rx();
    rx_byte_q.delete();
    rx_start_q.delete();
    rx_err = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nonce_valid = i[0];
      nonce_in    = $urandom;
      @(negedge hash_clk);
    end
    nonce_valid = 1'b0;
    reset = 1'b0;
    @(negedge hash_clk);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rst_tx got=%b exp=1", uart_tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
    repeat (20) @(negedge hash_clk);
    checks++; if (uart_tx !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_ignored_valid tx=%b busy=%b exp tx=1 busy=0", uart_tx, busy);
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] v;
    logic [7:0]  b;
    logic        exp_bits[160];
    int          k;
    v = 32'h12345678;
    k = 0;
    for (int j = 0; j < 4; j++) begin
      b = v[31 - 8*j -: 8];
      for (int c = 0; c < CPB; c++) exp_bits[k++] = 1'b0;
      for (int n = 0; n < 8; n++)
        for (int c = 0; c < CPB; c++) exp_bits[k++] = b[n];
      for (int c = 0; c < CPB; c++) exp_bits[k++] = 1'b1;
    end
    clear_rx();
    exp_q.push_back(v);
    push(v);
    checks++; if (uart_tx !== 1'b1 || fifo_count !== 3'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL lat_edge_n tx=%b count=%0d busy=%b exp tx=1 count=1 busy=1", uart_tx, fifo_count, busy);
    end
    @(negedge hash_clk);
    checks++; if (uart_tx !== 1'b1 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL lat_edge_n1 tx=%b count=%0d exp tx=1 count=0", uart_tx, fifo_count);
    end
    for (int i = 0; i < 160; i++) begin
      @(negedge hash_clk);
      checks++;
      if (uart_tx !== exp_bits[i]) begin
        errors++; $display("FAIL wave_bit%0d got=%b exp=%b", i, uart_tx, exp_bits[i]);
      end
    end
    @(negedge hash_clk);
    checks++; if (uart_tx !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL single_end tx=%b busy=%b exp tx=1 busy=0", uart_tx, busy);
    end
    wait_drain(100);
    checks++; if (exp_q.size() != 0 || rx_err != 0) begin
      errors++; $display("FAIL single_drain pending=%0d framing_err=%0d exp 0 0", exp_q.size(), rx_err);
    end
  endtask

  task automatic test_back_to_back();
    clear_rx();
    exp_q.push_back(32'hAAAAAAAA);
    exp_q.push_back(32'h00000001);
    nonce_valid = 1'b1;
    nonce_in    = 32'hAAAAAAAA;
    @(negedge hash_clk);
    nonce_in    = 32'h00000001;
    @(negedge hash_clk);
    nonce_valid = 1'b0;
    wait_drain(600);
    checks++; if (exp_q.size() != 0 || rx_err != 0) begin
      errors++; $display("FAIL b2b_drain pending=%0d framing_err=%0d exp 0 0", exp_q.size(), rx_err);
    end
    checks++;
    if (rx_start_q.size() < 8) begin
      errors++; $display("FAIL b2b_starts got=%0d exp=8", rx_start_q.size());
    end else begin
      if (rx_start_q[1] - rx_start_q[0] != 10*CPB) begin
        errors++; $display("FAIL b2b_byte_spacing got=%0d exp=%0d", rx_start_q[1] - rx_start_q[0], 10*CPB);
      end
      checks++;
      if (rx_start_q[4] - rx_start_q[3] != 10*CPB + 1) begin
        errors++; $display("FAIL b2b_frame_gap got=%0d exp=%0d", rx_start_q[4] - rx_start_q[3], 10*CPB + 1);
      end
      checks++;
      if (rx_start_q[4] - rx_start_q[0] != 40*CPB + 1) begin
        errors++; $display("FAIL b2b_frame_period got=%0d exp=%0d", rx_start_q[4] - rx_start_q[0], 40*CPB + 1);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    clear_rx();
    for (int i = 0; i < 6; i++) begin
      v = $urandom;
      if (i < 5) exp_q.push_back(v);
      nonce_valid = 1'b1;
      nonce_in    = v;
      @(negedge hash_clk);
      if (i == 4) begin
        checks++; if (overflow !== 1'b0 || fifo_count !== 3'd4) begin
          errors++; $display("FAIL ovf_full ovf=%b count=%0d exp ovf=0 count=4", overflow, fifo_count);
        end
      end
    end
    nonce_valid = 1'b0;
    checks++; if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
      errors++; $display("FAIL ovf_drop ovf=%b count=%0d exp ovf=1 count=4", overflow, fifo_count);
    end
    wait_drain(1000);
    checks++; if (exp_q.size() != 0 || rx_err != 0) begin
      errors++; $display("FAIL ovf_drain pending=%0d framing_err=%0d exp 0 0", exp_q.size(), rx_err);
    end
    repeat (200) @(negedge hash_clk);
    checks++; if (rx_byte_q.size() != 0 || overflow !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL ovf_sticky extra_bytes=%0d ovf=%b busy=%b exp 0 1 0", rx_byte_q.size(), overflow, busy);
    end
    reset = 1'b1;
    @(negedge hash_clk);
    reset = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_push_at_pop();
    logic [31:0] v;
    int t;
    clear_rx();
    for (int i = 0; i < 5; i++) begin
      v = $urandom;
      exp_q.push_back(v);
      nonce_valid = 1'b1;
      nonce_in    = v;
      @(negedge hash_clk);
    end
    nonce_valid = 1'b0;
    for (t = 0; t < 300 && !(dbg_state == 2'd0 && fifo_count == 3'd4); t++) @(negedge hash_clk);
    checks++;
    if (t >= 300) begin
      errors++; $display("FAIL pop_wait_timeout got=%0d exp<300", t);
    end else begin
      v = $urandom;
      exp_q.push_back(v);
      push(v);
      checks++; if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
        errors++; $display("FAIL push_at_pop count=%0d ovf=%b exp count=4 ovf=0", fifo_count, overflow);
      end
    end
    wait_drain(1300);
    checks++; if (exp_q.size() != 0 || rx_err != 0 || overflow !== 1'b0) begin
      errors++; $display("FAIL pop_drain pending=%0d framing_err=%0d ovf=%b exp 0 0 0", exp_q.size(), rx_err, overflow);
    end
  endtask

  task automatic test_reset_mid_frame();
    int t, lows;
    clear_rx();
    push($urandom);
    push($urandom);
    for (t = 0; t < 10 && uart_tx !== 1'b0; t++) @(negedge hash_clk);
    repeat (49) @(negedge hash_clk);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL mid_count_pre got=%0d exp=1", fifo_count); end
    sb_en = 1'b0;
    reset = 1'b1;
    @(negedge hash_clk);
    reset = 1'b0;
    checks++; if (uart_tx !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset tx=%b count=%0d busy=%b exp 1 0 0", uart_tx, fifo_count, busy);
    end
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge hash_clk);
      if (uart_tx !== 1'b1) lows++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL mid_quiet low_cycles=%0d exp=0", lows); end
    exp_q.delete();
    clear_rx();
    sb_en = 1'b1;
    exp_q.push_back(32'hC0FFEE42);
    push(32'hC0FFEE42);
    wait_drain(300);
    checks++; if (exp_q.size() != 0 || rx_err != 0) begin
      errors++; $display("FAIL mid_after pending=%0d framing_err=%0d exp 0 0", exp_q.size(), rx_err);
    end
  endtask

  task automatic test_random_stream();
    logic [31:0] v;
    int t, stalls;
    clear_rx();
    stalls = 0;
    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 200)) @(negedge hash_clk);
      for (t = 0; t < 400 && fifo_count == 3'd4; t++) @(negedge hash_clk);
      if (t >= 400) stalls++;
      v = $urandom;
      exp_q.push_back(v);
      push(v);
    end
    checks++; if (stalls != 0) begin errors++; $display("FAIL rand_stall got=%0d exp=0", stalls); end
    wait_drain(200 * 170 + 1000);
    checks++; if (exp_q.size() != 0 || rx_err != 0 || overflow !== 1'b0) begin
      errors++; $display("FAIL rand_drain pending=%0d framing_err=%0d ovf=%b exp 0 0 0", exp_q.size(), rx_err, overflow);
    end
  endtask

  initial begin
    @(negedge hash_clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_push_at_pop();
    test_reset_mid_frame();
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
